// File: rtl/test_harness_ctrl_if.sv
// rtl/test_harness_ctrl_if.sv - program-load stream, imem write, core monitor and verdict bundle
interface test_harness_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 8,
  parameter int CNT_W = 32
);
  logic              start;
  logic              clear;
  logic              ld_valid;
  logic              ld_ready;
  logic [XLEN-1:0]   ld_data;
  logic              ld_last;
  logic              imem_we;
  logic [AW-1:0]     imem_addr;
  logic [XLEN-1:0]   imem_wdata;
  logic              core_rst_n;
  logic [XLEN-1:0]   pc_in;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic              done;
  logic [2:0]        result;
  logic [XLEN-2:0]   fail_code;
  logic [CNT_W-1:0]  cycles;
  logic              load_ovf;

  modport master (
    input  start, clear, ld_valid, ld_data, ld_last,
    input  pc_in, dmem_we, dmem_addr, dmem_wdata,
    output ld_ready, imem_we, imem_addr, imem_wdata, core_rst_n,
    output done, result, fail_code, cycles, load_ovf
  );

  modport slave (
    output start, clear, ld_valid, ld_data, ld_last,
    output pc_in, dmem_we, dmem_addr, dmem_wdata,
    input  ld_ready, imem_we, imem_addr, imem_wdata, core_rst_n,
    input  done, result, fail_code, cycles, load_ovf
  );
endinterface

// File: rtl/test_harness_ctrl.sv
// rtl/test_harness_ctrl.sv - program loader, core release and verdict monitor for the RV32 core
module test_harness_ctrl #(
  parameter int              XLEN         = 32,
  parameter int              IMEM_DEPTH   = 256,
  parameter int              CNT_W        = 32,
  parameter int              MAX_CYCLES   = 100000,
  parameter int              STALL_CYCLES = 8,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_1000
) (
  input logic                 clk,
  input logic                 rst_n,
  test_harness_ctrl_if.master bus
);
  localparam int          AW      = $clog2(IMEM_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(IMEM_DEPTH);

  localparam logic [2:0] RES_NONE    = 3'd0;
  localparam logic [2:0] RES_PASS    = 3'd1;
  localparam logic [2:0] RES_FAIL    = 3'd2;
  localparam logic [2:0] RES_TIMEOUT = 3'd3;
  localparam logic [2:0] RES_STALL   = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [AW:0]      r_addr;
  logic             r_ld_ready;
  logic             r_core_rst_n;
  logic             r_done;
  logic [2:0]       r_result;
  logic [XLEN-2:0]  r_fail_code;
  logic [CNT_W-1:0] r_cycles;
  logic             r_load_ovf;
  logic [XLEN-1:0]  r_pc_prev;
  logic             r_pc_vld;
  logic [CNT_W-1:0] r_stall;

  logic             w_hs;
  logic             w_in_range;
  logic             w_tohost;
  logic             w_stall;
  logic             w_timeout;
  logic [CNT_W-1:0] w_stall_next;

  assign w_hs       = bus.ld_valid & r_ld_ready;
  assign w_in_range = (r_addr < DEPTH_L);

  assign bus.ld_ready   = r_ld_ready;
  assign bus.imem_we    = w_hs & w_in_range;
  assign bus.imem_addr  = r_addr[AW-1:0];
  assign bus.imem_wdata = bus.ld_data;
  assign bus.core_rst_n = r_core_rst_n;
  assign bus.done       = r_done;
  assign bus.result     = r_result;
  assign bus.fail_code  = r_fail_code;
  assign bus.cycles     = r_cycles;
  assign bus.load_ovf   = r_load_ovf;

  // Run length of an unchanged PC including this cycle; the first RUN cycle has no predecessor.
  assign w_stall_next = (r_pc_vld && (bus.pc_in == r_pc_prev)) ? r_stall + 1'b1 : '0;
  assign w_stall      = (STALL_CYCLES > 0) && (w_stall_next == CNT_W'(STALL_CYCLES));
  assign w_tohost     = bus.dmem_we && (bus.dmem_addr == TOHOST_ADDR);
  assign w_timeout    = (r_cycles == CNT_W'(MAX_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_ld_ready   <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= RES_NONE;
      r_fail_code  <= '0;
      r_cycles     <= '0;
      r_load_ovf   <= 1'b0;
      r_pc_prev    <= '0;
      r_pc_vld     <= 1'b0;
      r_stall      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_LOAD;
            r_ld_ready  <= 1'b1;
            r_addr      <= '0;
            r_load_ovf  <= 1'b0;
            r_result    <= RES_NONE;
            r_fail_code <= '0;
            r_cycles    <= '0;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            if (w_in_range) r_addr <= r_addr + 1'b1;
            else            r_load_ovf <= 1'b1;
            if (bus.ld_last) begin
              r_state      <= S_RUN;
              r_ld_ready   <= 1'b0;
              r_core_rst_n <= 1'b1;
              r_pc_vld     <= 1'b0;
              r_stall      <= '0;
            end
          end
        end
        S_RUN: begin
          r_cycles  <= r_cycles + 1'b1;
          r_pc_prev <= bus.pc_in;
          r_pc_vld  <= 1'b1;
          r_stall   <= w_stall_next;
          if (w_tohost || w_stall || w_timeout) begin
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_core_rst_n <= 1'b0;
          end
          // Same-cycle priority: tohost, then stall, then timeout.
          if (w_tohost) begin
            if (bus.dmem_wdata == XLEN'(1)) begin
              r_result <= RES_PASS;
            end else begin
              r_result    <= RES_FAIL;
              r_fail_code <= bus.dmem_wdata[XLEN-1:1];
            end
          end else if (w_stall) begin
            r_result <= RES_STALL;
          end else if (w_timeout) begin
            r_result <= RES_TIMEOUT;
          end
        end
        S_DONE: begin
          if (bus.clear) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_test_harness_ctrl.sv
// tb/tb_test_harness_ctrl.sv - randomized self-checking bench for test_harness_ctrl
module tb_test_harness_ctrl;
  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 8;
  localparam int          AW     = 3;
  localparam int          CNT_W  = 16;
  localparam int          MAXC   = 30;
  localparam int          STALLC = 4;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  test_harness_ctrl_if #(.XLEN(XLEN), .AW(AW), .CNT_W(CNT_W)) bus ();

  test_harness_ctrl #(
    .XLEN(XLEN), .IMEM_DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_CYCLES(MAXC),
    .STALL_CYCLES(STALLC), .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] pc_a [0:MAXC];
  logic        we_a [0:MAXC];
  logic [31:0] ad_a [0:MAXC];
  logic [31:0] da_a [0:MAXC];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Core behaviour per RUN cycle k (1-based): PC, store strobe, address, data.
  task automatic gen_scenario(input int mode);
    int t;
    for (int k = 0; k <= MAXC; k++) begin
      pc_a[k] = 32'h100 + 32'(4 * k);
      if (k > 1 && $urandom_range(0, 3) == 0) pc_a[k] = pc_a[k-1];
      we_a[k] = ($urandom_range(0, 3) == 0);
      ad_a[k] = TOHOST + 32'(4 * $urandom_range(1, 3));
      if (!we_a[k] && $urandom_range(0, 1) == 1) ad_a[k] = TOHOST;
      da_a[k] = $urandom;
    end
    case (mode)
      0, 1: begin
        t = $urandom_range(1, MAXC);
        we_a[t] = 1'b1;
        ad_a[t] = TOHOST;
        da_a[t] = (mode == 0) ? 32'd1 : ($urandom | 32'd2);
      end
      2: begin
        t = $urandom_range(1, MAXC - STALLC - 1);
        for (int k = t; k <= MAXC; k++) pc_a[k] = pc_a[t];
      end
      3: begin
        for (int k = 0; k <= MAXC; k++) pc_a[k] = 32'h100 + 32'(4 * k);
      end
      4: begin
        for (int k = 0; k <= MAXC; k++) begin
          pc_a[k] = 32'(4 * (k - 1));
          we_a[k] = 1'b0;
        end
        we_a[3] = 1'b1; ad_a[3] = TOHOST; da_a[3] = 32'd1;
      end
      5: begin
        we_a[2] = 1'b1; ad_a[2] = TOHOST; da_a[2] = 32'h0000_0007;
      end
      6, 7: begin
        for (int k = 0; k <= MAXC; k++) begin
          pc_a[k] = 32'h0;
          we_a[k] = 1'b0;
        end
        if (mode == 7) begin
          we_a[STALLC+1] = 1'b1; ad_a[STALLC+1] = TOHOST; da_a[STALLC+1] = 32'd1;
        end
      end
      default: begin
        for (int k = 0; k <= MAXC; k++) begin
          pc_a[k] = 32'h100 + 32'(4 * k);
          we_a[k] = 1'b0;
        end
        we_a[MAXC] = 1'b1; ad_a[MAXC] = TOHOST; da_a[MAXC] = 32'd5;
      end
    endcase
  endtask

  // Reference: first cycle with an event decides; tohost beats stall beats timeout.
  task automatic model(output int res, output int cyc, output logic [31:0] fc);
    int run;
    run = 0;
    res = 3; cyc = MAXC; fc = 32'd0;
    for (int k = 1; k <= MAXC; k++) begin
      if (k > 1 && pc_a[k] == pc_a[k-1]) run++;
      else run = 0;
      if (we_a[k] && ad_a[k] == TOHOST) begin
        res = (da_a[k] == 32'd1) ? 1 : 2;
        fc  = da_a[k] >> 1;
        cyc = k;
        return;
      end
      if (STALLC > 0 && run == STALLC) begin
        res = 4; cyc = k;
        return;
      end
    end
  endtask

  task automatic load_prog(input int n, input bit gaps);
    logic [31:0] w;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("ld_ready_after_start", bus.ld_ready, 1);
    check_eq("core_rst_in_load", bus.core_rst_n, 0);
    check_eq("result_cleared", bus.result, 0);
    check_eq("cycles_cleared", bus.cycles, 0);
    check_eq("ovf_cleared", bus.load_ovf, 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          bus.ld_valid = 1'b0;
          bus.start = 1'($urandom_range(0, 1));
          #1;
          check_eq("gap_no_write", bus.imem_we, 0);
          @(posedge clk); #1;
        end
        bus.start = 1'b0;
      end
      w = $urandom;
      bus.ld_valid = 1'b1;
      bus.ld_data  = w;
      bus.ld_last  = (i == n - 1);
      #1;
      check_eq("imem_we", bus.imem_we, (i < DEPTH));
      if (i < DEPTH) begin
        check_eq("imem_addr", bus.imem_addr, i);
        check_eq("imem_wdata", bus.imem_wdata, w);
      end
      @(posedge clk); #1;
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
    end
    check_eq("core_released", bus.core_rst_n, 1);
    check_eq("ld_ready_in_run", bus.ld_ready, 0);
    check_eq("load_ovf", bus.load_ovf, (n > DEPTH));
  endtask

  task automatic run_phase();
    int          er, ec;
    logic [31:0] ef;
    model(er, ec, ef);
    for (int k = 1; k <= ec; k++) begin
      bus.pc_in      = pc_a[k];
      bus.dmem_we    = we_a[k];
      bus.dmem_addr  = ad_a[k];
      bus.dmem_wdata = da_a[k];
      #1;
      if (k == ec) check_eq("done_not_early", bus.done, 0);
      @(posedge clk); #1;
    end
    bus.dmem_we = 1'b0;
    check_eq("done", bus.done, 1);
    check_eq("result", bus.result, er);
    check_eq("cycles", bus.cycles, ec);
    if (er == 2) check_eq("fail_code", bus.fail_code, ef);
    check_eq("core_rst_after_done", bus.core_rst_n, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("done_hold_on_start", bus.done, 1);
    check_eq("result_hold", bus.result, er);
    check_eq("ld_ready_in_done", bus.ld_ready, 0);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    check_eq("done_after_clear", bus.done, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.clear = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0;
    bus.ld_last = 1'b0; bus.pc_in = '0; bus.dmem_we = 1'b0; bus.dmem_addr = '0;
    bus.dmem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_result", bus.result, 0);
    check_eq("rst_fail_code", bus.fail_code, 0);
    check_eq("rst_cycles", bus.cycles, 0);
    check_eq("rst_load_ovf", bus.load_ovf, 0);
    check_eq("rst_core_rst_n", bus.core_rst_n, 0);
    check_eq("rst_ld_ready", bus.ld_ready, 0);
    check_eq("rst_imem_addr", bus.imem_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    gen_scenario(4); load_prog(4, 1'b0);  run_phase();
    gen_scenario(5); load_prog(3, 1'b1);  run_phase();
    gen_scenario(6); load_prog(1, 1'b0);  run_phase();
    gen_scenario(3); load_prog(2, 1'b1);  run_phase();
    gen_scenario(0); load_prog(10, 1'b1); run_phase();
    gen_scenario(7); load_prog(2, 1'b0);  run_phase();
    gen_scenario(8); load_prog(DEPTH, 1'b0); run_phase();

    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = $urandom;
      @(posedge clk); #1;
    end
    check_eq("partial_addr", bus.imem_addr, 3);
    rst_n = 1'b0;
    #1;
    check_eq("async_ld_ready", bus.ld_ready, 0);
    check_eq("async_imem_we", bus.imem_we, 0);
    check_eq("async_imem_addr", bus.imem_addr, 0);
    check_eq("async_core_rst_n", bus.core_rst_n, 0);
    check_eq("async_done", bus.done, 0);
    check_eq("async_result", bus.result, 0);
    check_eq("async_cycles", bus.cycles, 0);
    bus.ld_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    gen_scenario(1); load_prog(5, 1'b1); run_phase();

    for (int r = 0; r < 20; r++) begin
      gen_scenario($urandom_range(0, 3));
      load_prog($urandom_range(1, 10), 1'($urandom_range(0, 1)));
      run_phase();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
